// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, status flags and sticky error flags.
// Optional per-word parity checking is enabled by defining SYNC_FIFO_PARITY_EN.
module sync_fifo #(
    parameter int DATAWIDTH = 8,
    parameter int ASIZE     = 4,
    parameter int AF_LEVEL  = (1 << ASIZE) - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 wen,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 wpar_inv,
    input  logic                 ren,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 rvalid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ASIZE:0]       count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 perr
);

    localparam int DEPTH = 1 << ASIZE;
`ifdef SYNC_FIFO_PARITY_EN
    localparam int MW = DATAWIDTH + 1;
`else
    localparam int MW = DATAWIDTH;
`endif

    logic [MW-1:0]  mem [DEPTH];
    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic           wr_acc;
    logic           rd_acc;
    logic [MW-1:0]  wr_word;
    logic [MW-1:0]  rd_word;

    // Flags decode only the pointer registers, so no input reaches them combinationally.
    assign count        = wptr - rptr;
    assign empty        = (wptr == rptr);
    assign full         = (wptr[ASIZE] != rptr[ASIZE]) &&
                          (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign almost_full  = (int'(count) >= AF_LEVEL);
    assign almost_empty = (int'(count) <= AE_LEVEL);

    // clr overrides both requests in the cycle it is asserted.
    assign wr_acc  = wen && !full && !clr;
    assign rd_acc  = ren && !empty && !clr;
    assign rd_word = mem[rptr[ASIZE-1:0]];

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {(^wdata) ^ wpar_inv, wdata};
`else
    assign wr_word = wdata;
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ASIZE-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr  <= rptr + 1'b1;
                rdata <= rd_word[DATAWIDTH-1:0];
            end
            if (wen && full) begin
                overflow <= 1'b1;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr <= 1'b0;
        end else if (clr) begin
            perr <= 1'b0;
        end else begin
            perr <= rd_acc && ((^rd_word[DATAWIDTH-1:0]) != rd_word[DATAWIDTH]);
        end
    end
`else
    logic unused_wpar_inv;
    assign unused_wpar_inv = wpar_inv;
    assign perr            = 1'b0;
`endif

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter ASIZE, default 4, meaning address bits; depth = 2^ASIZE words (16 by default).
REQ-003 The block SHALL have parameter AF_LEVEL, default 2^ASIZE-2, meaning the almost_full threshold in words.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning the almost_empty threshold in words.
REQ-005 The block SHALL have port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port clr  input  1  synchronous flush.
REQ-008 The block SHALL have port wen  input  1  write request.
REQ-009 The block SHALL have port wdata  input  DATAWIDTH  write data.
REQ-010 The block SHALL have port wpar_inv  input  1  parity error injection, inverting the stored parity bit of this write.
REQ-011 The block SHALL have port ren  input  1  read request.
REQ-012 The block SHALL have port rdata  output  DATAWIDTH  registered read data.
REQ-013 The block SHALL have port rvalid  output  1  rdata carries a newly popped word.
REQ-014 The block SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 The block SHALL have port count  output  ASIZE+1  number of stored words, range 0..2^ASIZE.
REQ-016 The block SHALL have ports overflow, underflow  output  1 each  sticky error flags.
REQ-017 The block SHALL have port perr  output  1  read parity error pulse.

Function
REQ-018 Write and read pointers SHALL be ASIZE+1 bits wide and wrap modulo 2^(ASIZE+1); the low ASIZE bits address memory.
REQ-019 A write SHALL be accepted iff wen=1 and full=0; an accepted write stores wdata at the write pointer and increments it.
REQ-020 A read SHALL be accepted iff ren=1 and empty=0; rdata SHALL show the popped word one cycle later with rvalid=1 for exactly that cycle.
REQ-021 When no read is accepted, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-022 Simultaneous accepted read and write SHALL leave count unchanged; on empty, the write is accepted and the read is rejected; on full, the read is accepted and the write is rejected.
REQ-023 Flag definitions:
- empty: pointers are equal.
- full: the pointer MSBs differ and the low bits are equal.
- almost_full: count >= AF_LEVEL.
- almost_empty: count <= AE_LEVEL.
REQ-024 All flags and count SHALL be decoded from registered state only, with no combinational path from any input, and SHALL reflect accepted operations from the next cycle.
REQ-025 overflow SHALL set on wen=1 while full=1; underflow SHALL set on ren=1 while empty=1; both SHALL stay set until clr or reset.
REQ-026 clr=1 SHALL, on the next edge, zero both pointers, count, rvalid, perr, overflow and underflow, leave rdata and the memory unchanged, and override wen and ren in the same cycle.
REQ-027 The memory array SHALL NOT be reset; its contents are undefined until written.

Reset
REQ-028 While reset=1: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rdata=0, rvalid=0, perr=0, overflow=0, underflow=0.
REQ-029 Reset asserted mid-operation SHALL abort any pending read (no rvalid afterwards); the first accepted write after deassertion SHALL land at address 0.

Configuration
REQ-030 With macro SYNC_FIFO_PARITY_EN defined:
- memory words SHALL be DATAWIDTH+1 bits, holding the even parity of wdata XOR wpar_inv.
- on every read, perr SHALL pulse coincident with rvalid when the recomputed parity mismatches the stored bit.
REQ-031 Without SYNC_FIFO_PARITY_EN:
- memory words SHALL be DATAWIDTH bits and wpar_inv SHALL be ignored.
- perr SHALL be constant 0; all ports remain present.

Verification
REQ-032 Reset, then write 0x01..0x10 (16 words, defaults) -> full=1 and count=16 after the last write; almost_full=1 from count 14; a 17th write sets overflow=1 and count stays 16.
REQ-033 From full, pop 16 words -> rdata 0x01..0x10 in order, each one cycle after its ren, with rvalid=1; empty=1 after the last; a further ren sets underflow=1 with rvalid=0.
REQ-034 Hold count=5 and assert wen and ren together for 40 cycles -> count stays 5, pointers wrap at least twice, and read data stays in write order.
REQ-035 On empty, assert wen=1 (wdata=0xA5) and ren=1 in the same cycle -> count=1, no rvalid; next-cycle ren -> rdata=0xA5, rvalid=1.
REQ-036 With 3 words stored plus overflow set, assert clr together with wen -> count=0, empty=1, overflow=0, and the write is discarded; repeat with reset pulsed mid-read -> rvalid stays 0.
REQ-037 With SYNC_FIFO_PARITY_EN, write 0x3C with wpar_inv=1 then 0x3D with wpar_inv=0, then pop both -> perr=1 on the first rvalid and 0 on the second; without the macro, perr=0 throughout.
